// File: rtl/button_event_decoder.sv
// Turns a debounced, clk-synchronous button level into single-cycle press/release/short/long/repeat
// events plus a held level; hold timing comes from an internal prescaler on clk.
module button_event_decoder #(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter int unsigned REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned PW = $clog2(PRESCALE + 1);
  localparam int unsigned LW = $clog2(LONG_TICKS + 1);
  localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOW,
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   psc_q, psc_d;
  logic [LW-1:0]   hold_q, hold_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            repeat_q, repeat_d;
  logic            held_q, held_d;
  logic            tick;

  assign tick = (psc_q == PW'(PRESCALE - 1));

  // Next-state, counters and event decode; a falling level always beats a same-edge timing event.
  always_comb begin
    state_d   = state_q;
    psc_d     = psc_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_WAIT_LOW: begin
        psc_d  = '0;
        hold_d = '0;
        rep_d  = '0;
        if (!level) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        psc_d  = '0;
        hold_d = '0;
        rep_d  = '0;
        if (level) begin
          state_d = ST_HELD;
          press_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (!level) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else begin
          psc_d = tick ? '0 : psc_q + PW'(1);
          if (tick) begin
            if (hold_q == LW'(LONG_TICKS - 1)) begin
              state_d = ST_LONG;
              long_d  = 1'b1;
              hold_d  = LW'(LONG_TICKS);
              rep_d   = '0;
            end else begin
              hold_d = hold_q + LW'(1);
            end
          end
        end
      end
      ST_LONG: begin
        if (!level) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          psc_d = tick ? '0 : psc_q + PW'(1);
          // Repeat counter wraps even with repeat disabled so it can never overflow.
          if (tick) begin
            if (rep_q == RW'(REPEAT_TICKS - 1)) begin
              rep_d    = '0;
              repeat_d = (REPEAT_EN != 0);
            end else begin
              rep_d = rep_q + RW'(1);
            end
          end
        end
      end
      default: state_d = ST_WAIT_LOW;
    endcase
    held_d = (state_d == ST_HELD) || (state_d == ST_LONG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_WAIT_LOW;
      psc_q     <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psc_q     <= psc_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder (PRESCALE=4, LONG_TICKS=3, REPEAT_TICKS=2);
// a second instance with repeat disabled shares the stimulus.
module tb_button_event_decoder;

  logic clk;
  logic reset;
  logic level;
  logic press_a, release_a, short_a, long_a, repeat_a, held_a;
  logic press_b, release_b, short_b, long_b, repeat_b, held_b;
  logic [5:0] obs;
  logic [5:0] obs2;
  logic [5:0] exp_v;
  int tests;
  int failed;

  button_event_decoder #(
    .PRESCALE(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .level(level),
    .press_pulse(press_a), .release_pulse(release_a), .short_pulse(short_a),
    .long_pulse(long_a), .repeat_pulse(repeat_a), .held(held_a)
  );

  button_event_decoder #(
    .PRESCALE(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .REPEAT_EN(0)
  ) dut_norep (
    .clk(clk), .reset(reset), .level(level),
    .press_pulse(press_b), .release_pulse(release_b), .short_pulse(short_b),
    .long_pulse(long_b), .repeat_pulse(repeat_b), .held(held_b)
  );

  // Bit order: {press, release, short, long, repeat, held}
  assign obs  = {press_a, release_a, short_a, long_a, repeat_a, held_a};
  assign obs2 = {press_b, release_b, short_b, long_b, repeat_b, held_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic lvl);
    level = lvl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    level = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs !== 6'b0) begin
      failed++;
      $display("FAIL reset_a obs=%b exp=%b", obs, 6'b0);
    end
    tests++;
    if (obs2 !== 6'b0) begin
      failed++;
      $display("FAIL reset_b obs=%b exp=%b", obs2, 6'b0);
    end
    reset = 1'b0;
    step(1'b0);
    tests++;
    if (obs !== 6'b0) begin
      failed++;
      $display("FAIL reset_idle obs=%b exp=%b", obs, 6'b0);
    end
  endtask

  task automatic test_short_press();
    for (int k = 0; k <= 6; k++) begin
      step((k < 5) ? 1'b1 : 1'b0);
      if (k == 0) exp_v = 6'b100001;
      else if (k < 5) exp_v = 6'b000001;
      else if (k == 5) exp_v = 6'b011000;
      else exp_v = 6'b000000;
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL short_press k=%0d obs=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_long_hold();
    for (int k = 0; k <= 31; k++) begin
      step((k < 30) ? 1'b1 : 1'b0);
      if (k == 0) exp_v = 6'b100001;
      else if (k == 12) exp_v = 6'b000101;
      else if (k == 20 || k == 28) exp_v = 6'b000011;
      else if (k < 30) exp_v = 6'b000001;
      else if (k == 30) exp_v = 6'b010000;
      else exp_v = 6'b000000;
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL long_hold k=%0d obs=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_boundary();
    for (int k = 0; k <= 13; k++) begin
      step((k < 12) ? 1'b1 : 1'b0);
      if (k == 0) exp_v = 6'b100001;
      else if (k < 12) exp_v = 6'b000001;
      else if (k == 12) exp_v = 6'b011000;
      else exp_v = 6'b000000;
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL boundary k=%0d obs=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_no_repeat();
    for (int k = 0; k <= 31; k++) begin
      step((k < 30) ? 1'b1 : 1'b0);
      if (k == 0) exp_v = 6'b100001;
      else if (k == 12) exp_v = 6'b000101;
      else if (k < 30) exp_v = 6'b000001;
      else if (k == 30) exp_v = 6'b010000;
      else exp_v = 6'b000000;
      tests++;
      if (obs2 !== exp_v) begin
        failed++;
        $display("FAIL no_repeat k=%0d obs=%b exp=%b", k, obs2, exp_v);
      end
    end
  endtask

  task automatic test_reset_level_high();
    level = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1);
      tests++;
      if (obs !== 6'b0) begin
        failed++;
        $display("FAIL stuck_high k=%0d obs=%b exp=%b", k, obs, 6'b0);
      end
    end
    step(1'b0);
    tests++;
    if (obs !== 6'b0) begin
      failed++;
      $display("FAIL stuck_low obs=%b exp=%b", obs, 6'b0);
    end
    step(1'b1);
    tests++;
    if (obs !== 6'b100001) begin
      failed++;
      $display("FAIL stuck_press obs=%b exp=%b", obs, 6'b100001);
    end
    step(1'b0);
    tests++;
    if (obs !== 6'b011000) begin
      failed++;
      $display("FAIL stuck_release obs=%b exp=%b", obs, 6'b011000);
    end
  endtask

  task automatic test_reset_mid_long();
    step(1'b0);
    for (int k = 0; k <= 14; k++) step(1'b1);
    tests++;
    if (obs !== 6'b000001) begin
      failed++;
      $display("FAIL mid_long_held obs=%b exp=%b", obs, 6'b000001);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (obs !== 6'b0) begin
      failed++;
      $display("FAIL async_reset obs=%b exp=%b", obs, 6'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      tests++;
      if (obs !== 6'b0) begin
        failed++;
        $display("FAIL post_reset_hold k=%0d obs=%b exp=%b", k, obs, 6'b0);
      end
    end
    step(1'b0);
    tests++;
    if (obs !== 6'b0) begin
      failed++;
      $display("FAIL post_reset_low obs=%b exp=%b", obs, 6'b0);
    end
    step(1'b1);
    tests++;
    if (obs !== 6'b100001) begin
      failed++;
      $display("FAIL post_reset_press obs=%b exp=%b", obs, 6'b100001);
    end
    step(1'b0);
    step(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [4:0] lv;
    logic [5:0] ev [5];
    lv = 5'b00101;
    ev[0] = 6'b100001;
    ev[1] = 6'b011000;
    ev[2] = 6'b100001;
    ev[3] = 6'b011000;
    ev[4] = 6'b000000;
    for (int k = 0; k < 5; k++) begin
      step(lv[k]);
      tests++;
      if (obs !== ev[k]) begin
        failed++;
        $display("FAIL back_to_back k=%0d obs=%b exp=%b", k, obs, ev[k]);
      end
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    level  = 1'b0;
    test_reset();
    test_short_press();
    test_long_hold();
    test_boundary();
    test_no_repeat();
    test_reset_level_high();
    test_reset_mid_long();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
